// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode constants, instruction field layout and
// the sequencer FSM state encoding (S_HOLD exists only with SEQ_SINGLE_STEP_EN).
package proc_pkg;

  localparam logic [3:0] OP_ZERO    = 4'b0000;
  localparam logic [3:0] OP_STORE_B = 4'b1011;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_HOLD
`endif
  } seq_state_t;

  function automatic logic is_halt(input logic [11:0] word);
    return word[OPC_LSB +: FIELD_W] == OP_HALT;
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Instruction ROM port plus the issue handshake towards control unit / ALU.
interface instruction_sequencer_if #(
  parameter int AW = 6,
  parameter int IW = 12
);
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [IW-1:0] imem_rdata;
  logic [3:0]    opcode;
  logic [3:0]    ra;
  logic [3:0]    rb;
  logic          instr_valid;
  logic          exec_ready;

  modport master (
    output imem_addr, imem_en, opcode, ra, rb, instr_valid,
    input  imem_rdata, exec_ready
  );

  modport slave (
    input  imem_addr, imem_en, opcode, ra, rb, instr_valid,
    output imem_rdata, exec_ready
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetch/issue sequencer: FETCH -> WAIT -> ISSUE per instruction, stops on HALT or last pc.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a HOLD state gating every fetch.
module instruction_sequencer
  import proc_pkg::*;
#(
  parameter int AW = 6,
  parameter int IW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  instruction_sequencer_if.master bus,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] PC_LAST = '1;
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  seq_state_t    state;
  logic [IW-1:0] ir;

  // IR is only loaded with issuable words, so the fields keep their last issued value.
  assign bus.opcode = ir[OPC_LSB +: FIELD_W];
  assign bus.ra     = ir[RA_LSB +: FIELD_W];
  assign bus.rb     = ir[RB_LSB +: FIELD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= '0;
      ir              <= '0;
      bus.instr_valid <= 1'b0;
      bus.imem_en     <= 1'b0;
      bus.imem_addr   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done        <= 1'b0;
      bus.imem_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc   <= '0;
            busy <= 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
            state <= S_HOLD;
`else
            state         <= S_FETCH;
            bus.imem_en   <= 1'b1;
            bus.imem_addr <= '0;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_HOLD: begin
          if (step) begin
            state         <= S_FETCH;
            bus.imem_en   <= 1'b1;
            bus.imem_addr <= pc;
          end
        end
`endif
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (is_halt(bus.imem_rdata[11:0])) begin
            state <= S_HALT;
            done  <= 1'b1;
          end else begin
            ir              <= bus.imem_rdata;
            state           <= S_ISSUE;
            bus.instr_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.exec_ready) begin
            bus.instr_valid <= 1'b0;
            if (pc == PC_LAST) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else begin
              pc <= pc + PC_ONE;
`ifdef SEQ_SINGLE_STEP_EN
              state <= S_HOLD;
`else
              state         <= S_FETCH;
              bus.imem_en   <= 1'b1;
              bus.imem_addr <= pc + PC_ONE;
`endif
            end
          end
        end
        S_HALT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer (AW=3): cycle table for a short program,
// then stall, pc-limit, start-while-busy and mid-issue reset sequences.
module tb_instruction_sequencer;
  import proc_pkg::*;

  localparam int AW = 3;
  localparam int IW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step;
`endif
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  instruction_sequencer_if #(.AW(AW), .IW(IW)) bus ();

  instruction_sequencer #(.AW(AW), .IW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus.master),
    .busy  (busy),
    .done  (done),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [2**AW];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];

  int n_chk  = 0;
  int n_fail = 0;
  logic [11:0] issued[$];
  logic [AW-1:0] pc_at_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog_a();
    foreach (rom[i]) rom[i] = 12'h000;
    rom[0] = 12'h112;
    rom[1] = 12'hA30;
    rom[2] = 12'hF00;
  endtask

  // Runs with current inputs until done, recording issued words; bounded.
  task automatic run_to_done(input string name, output int issues);
    int got;
    got    = 0;
    issues = 0;
    for (int c = 0; c < 60 && got == 0; c++) begin
      @(negedge clk);
      if (bus.instr_valid && bus.exec_ready) begin
        issues++;
        issued.push_back({bus.opcode, bus.ra, bus.rb});
      end
      if (done) begin
        got        = 1;
        pc_at_done = pc;
      end
      tick();
    end
    chk({name, " done seen"}, got, 1);
  endtask

  typedef struct {
    logic          start;
    logic          rdy;
    logic          iv;
    logic [3:0]    op;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic          en;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
  } vec_t;

  vec_t vt[12];

  task automatic setv(input int i, input int st, input int rdy, input int iv, input int op,
                      input int ra, input int rb, input int en, input int addr,
                      input int bz, input int dn, input int p);
    vt[i].start = 1'(st);  vt[i].rdy = 1'(rdy); vt[i].iv = 1'(iv);
    vt[i].op    = 4'(op);  vt[i].ra  = 4'(ra);  vt[i].rb = 4'(rb);
    vt[i].en    = 1'(en);  vt[i].addr = AW'(addr);
    vt[i].busy  = 1'(bz);  vt[i].done = 1'(dn); vt[i].pc = AW'(p);
  endtask

  initial begin
    int n;
    int dones;
    int fetches;
    rst = 1'b1;
    start = 1'b0;
    bus.exec_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    load_prog_a();
    tick();
    tick();
    rst = 1'b0;

    @(negedge clk);
    chk("reset instr_valid", bus.instr_valid, 0);
    chk("reset imem_en", bus.imem_en, 0);
    chk("reset imem_addr", bus.imem_addr, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pc", pc, 0);
    chk("reset fields", {bus.opcode, bus.ra, bus.rb}, 0);
    tick();

`ifdef SEQ_SINGLE_STEP_EN
    rom[2] = 12'h2C5;
    rom[3] = 12'hF00;
    bus.exec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fetches = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fetches += int'(bus.imem_en);
      tick();
    end
    chk("step: no fetch before first step", fetches, 0);
    chk("step: busy while holding", busy, 1);
    dones = 0;
    for (int s = 0; s < 4; s++) begin
      fetches = 0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
        step = (c == 0);
        @(negedge clk);
        fetches += int'(bus.imem_en);
        n += int'(bus.instr_valid && bus.exec_ready);
        dones += int'(done);
        tick();
      end
      step = 1'b0;
      chk($sformatf("step %0d fetches", s), fetches, 1);
      chk($sformatf("step %0d issues", s), n, (s < 3) ? 1 : 0);
    end
    chk("step: single done", dones, 1);
    chk("step: idle after halt", busy, 0);
`else
    // Program A, exec_ready high: cycle-by-cycle expectations.
    //      i  st rdy iv op   ra rb en ad bz dn pc
    setv(0,  1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    setv(1,  0, 1, 0, 0,   0, 0, 1, 0, 1, 0, 0);
    setv(2,  0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    setv(3,  0, 1, 1, 1,   1, 2, 0, 0, 1, 0, 0);
    setv(4,  0, 1, 0, 0,   0, 0, 1, 1, 1, 0, 1);
    setv(5,  0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 1);
    setv(6,  0, 1, 1, 10,  3, 0, 0, 0, 1, 0, 1);
    setv(7,  0, 1, 0, 0,   0, 0, 1, 2, 1, 0, 2);
    setv(8,  0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 2);
    setv(9,  0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 2);
    setv(10, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    setv(11, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 12; i++) begin
      start = vt[i].start;
      bus.exec_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("t1[%0d] instr_valid", i), bus.instr_valid, vt[i].iv);
      if (vt[i].iv) begin
        chk($sformatf("t1[%0d] fields", i), {bus.opcode, bus.ra, bus.rb},
            {vt[i].op, vt[i].ra, vt[i].rb});
      end
      chk($sformatf("t1[%0d] imem_en", i), bus.imem_en, vt[i].en);
      if (vt[i].en) chk($sformatf("t1[%0d] imem_addr", i), bus.imem_addr, vt[i].addr);
      chk($sformatf("t1[%0d] busy", i), busy, vt[i].busy);
      chk($sformatf("t1[%0d] done", i), done, vt[i].done);
      chk($sformatf("t1[%0d] pc", i), pc, vt[i].pc);
      tick();
    end
    start = 1'b0;

    // Four stall cycles on the first instruction.
    bus.exec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.exec_ready = (k == 4);
      @(negedge clk);
      chk($sformatf("stall[%0d] instr_valid", k), bus.instr_valid, 1);
      chk($sformatf("stall[%0d] fields", k), {bus.opcode, bus.ra, bus.rb}, 12'h112);
      chk($sformatf("stall[%0d] pc", k), pc, 0);
      tick();
    end
    @(negedge clk);
    chk("stall next fetch en", bus.imem_en, 1);
    chk("stall next fetch addr", bus.imem_addr, 1);
    tick();
    issued.delete();
    run_to_done("stall", n);
    chk("stall remaining issues", n, 1);

    // No HALT in ROM: pc limit ends the run.
    foreach (rom[i]) rom[i] = 12'h100;
    issued.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("pclimit", n);
    chk("pclimit issue count", n, 8);
    chk("pclimit pc at done", pc_at_done, 7);
    chk("pclimit last word", issued[issued.size()-1], 12'h100);
    @(negedge clk);
    chk("pclimit idle after done", busy, 0);
    tick();

    // start pulses while busy, including during the done cycle.
    load_prog_a();
    issued.delete();
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      start = (c == 0 || c == 2 || c == 5 || c == 9);
      @(negedge clk);
      if (bus.instr_valid && bus.exec_ready) issued.push_back({bus.opcode, bus.ra, bus.rb});
      dones += int'(done);
      tick();
    end
    start = 1'b0;
    chk("busy-start issue count", issued.size(), 2);
    if (issued.size() == 2) begin
      chk("busy-start issue 0", issued[0], 12'h112);
      chk("busy-start issue 1", issued[1], 12'hA30);
    end
    chk("busy-start dones", dones, 1);
    chk("busy-start idle at end", busy, 0);

    // Reset during an ISSUE handshake.
    bus.exec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst-mid in issue", bus.instr_valid, 1);
    bus.exec_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst-mid instr_valid", bus.instr_valid, 0);
    chk("rst-mid busy", busy, 0);
    chk("rst-mid pc", pc, 0);
    chk("rst-mid imem_en", bus.imem_en, 0);
    dones = int'(done);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dones += int'(done);
      tick();
    end
    chk("rst-mid no done", dones, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst-mid restart valid", bus.instr_valid, 1);
    chk("rst-mid restart fields", {bus.opcode, bus.ra, bus.rb}, 12'h112);
    chk("rst-mid restart pc", pc, 0);
    tick();
    issued.delete();
    run_to_done("rst-mid rerun", n);
    chk("rst-mid rerun issues", n, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
